// File: rtl/datapath_control_unit.sv
// datapath_control_unit
//   Hardwired control sequencer for the single-bus CPU datapath. A registered
//   step state (RST, T0..T6, HALT) plus the opcode in IR[31:27] is decoded
//   Moore-style into the datapath strobes. Fetch is T0..T2. The execute steps
//   for ALU, mul/div and unary instructions follow. nop, undefined opcodes and
//   halt leave the sequence after T2.
// Ports:
//   Clock, Reset_n          clock, async active-low reset
//   IR[31:0]                instruction register (opcode in IR[31:27])
//   Stop                    halt request, honoured at the instruction boundary
//   PCout..MDRout           bus drive enables
//   MARin..LOin             register load enables
//   IncPC, Read             PC+1 in ALU, memory read
//   Gra/Grb/Grc, Rin/Rout   general register select / load / drive
//   ALU_op[4:0]             ALU operation, opcode during execute Zin steps only
//   Run                     low only in HALT
module datapath_control_unit #(
  parameter int OPW = 5,
  parameter int STW = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [OPW-1:0] ALU_op,
  output logic        Run
);

  localparam logic [STW-1:0] S_RST  = STW'(0);
  localparam logic [STW-1:0] S_T0   = STW'(1);
  localparam logic [STW-1:0] S_T1   = STW'(2);
  localparam logic [STW-1:0] S_T2   = STW'(3);
  localparam logic [STW-1:0] S_T3   = STW'(4);
  localparam logic [STW-1:0] S_T4   = STW'(5);
  localparam logic [STW-1:0] S_T5   = STW'(6);
  localparam logic [STW-1:0] S_T6   = STW'(7);
  localparam logic [STW-1:0] S_HALT = STW'(8);

  logic [STW-1:0] state, state_nx;
  logic [OPW-1:0] op;
  logic is_bin, is_md, is_un, is_halt;
  logic [STW-1:0] boundary;

  assign op = IR[31 -: OPW];
  // Register fields are routed by the select-and-encode logic, not here.
  logic unused_ir;
  assign unused_ir = &{1'b0, IR[31-OPW:0]};

  assign is_bin  = (op >= OPW'(5'b00011)) && (op <= OPW'(5'b01010));
  assign is_md   = (op == OPW'(5'b01111)) || (op == OPW'(5'b10000));
  assign is_un   = (op == OPW'(5'b10001)) || (op == OPW'(5'b10010));
  assign is_halt = (op == OPW'(5'b11011));

  // Stop only matters on the edge that would start the next fetch.
  assign boundary = Stop ? S_HALT : S_T0;

  always_comb begin
    state_nx = S_RST;
    case (state)
      S_RST:  state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   state_nx = S_T2;
      // Branch on the opcode as IR presents it at the end of fetch.
      S_T2:   state_nx = is_halt ? S_HALT :
                         (is_bin || is_md || is_un) ? S_T3 : boundary;
      S_T3:   state_nx = S_T4;
      S_T4:   state_nx = is_un ? boundary : S_T5;
      S_T5:   state_nx = is_md ? S_T6 : boundary;
      S_T6:   state_nx = boundary;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state <= S_RST;
    else          state <= state_nx;

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    ALU_op = '0; Run = 1'b1;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Grb = 1'b1; Rout = 1'b1;
        if (is_un) begin Zin = 1'b1; ALU_op = op; end
        else       Yin = 1'b1;
      end
      S_T4: begin
        if (is_un) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op; end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6:   begin Zhighout = 1'b1; HIin = 1'b1; end
      S_HALT: Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit. Outputs are compared once per
// cycle at the falling edge against hand-written per-step strobe masks.
module tb_datapath_control_unit;
  logic Clock, Reset_n, Stop;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
  logic [4:0] ALU_op;

  datapath_control_unit dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ALU_op(ALU_op), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [18:0] PCO = 19'd1 << 18, ZHO = 19'd1 << 17, ZLO = 19'd1 << 16;
  localparam logic [18:0] MDO = 19'd1 << 15, MAI = 19'd1 << 14, ZI  = 19'd1 << 13;
  localparam logic [18:0] PCI = 19'd1 << 12, MDI = 19'd1 << 11, IRI = 19'd1 << 10;
  localparam logic [18:0] YI  = 19'd1 << 9,  HII = 19'd1 << 8,  LOI = 19'd1 << 7;
  localparam logic [18:0] INC = 19'd1 << 6,  RD  = 19'd1 << 5,  GA  = 19'd1 << 4;
  localparam logic [18:0] GB  = 19'd1 << 3,  GC  = 19'd1 << 2,  RI  = 19'd1 << 1;
  localparam logic [18:0] RO  = 19'd1;

  logic [18:0] strb;
  assign strb = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                 Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare this cycle's outputs, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [18:0] s, input logic [4:0] op,
                     input logic run);
    chk(tag, {strb, ALU_op, Run}, {s, op, run});
    @(negedge Clock);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T0"}, PCO | MAI | INC | ZI, 5'd0, 1'b1);
    cyc({tag, ".T1"}, ZLO | PCI | RD | MDI, 5'd0, 1'b1);
    cyc({tag, ".T2"}, MDO | IRI, 5'd0, 1'b1);
  endtask

  // Release reset just after a rising edge so RST lasts one full cycle.
  task automatic release_rst(input string tag);
    @(posedge Clock); #1 Reset_n = 1'b1;
    @(negedge Clock);
    cyc({tag, ".rst"}, 19'd0, 5'd0, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0; Stop = 1'b0; IR = 32'h0;
    @(negedge Clock); @(negedge Clock);
    chk("in_reset", {strb, ALU_op, Run}, {19'd0, 5'd0, 1'b1});
    IR = 32'h28918000;                       // and R1,R2,R3
    release_rst("boot");
    fetch("and");
    cyc("and.T3", GB | RO | YI, 5'd0, 1'b1);
    cyc("and.T4", GC | RO | ZI, 5'b00101, 1'b1);
    cyc("and.T5", ZLO | GA | RI, 5'd0, 1'b1);

    IR = 32'h78918000;                       // mul
    fetch("mul");
    cyc("mul.T3", GB | RO | YI, 5'd0, 1'b1);
    cyc("mul.T4", GC | RO | ZI, 5'b01111, 1'b1);
    cyc("mul.T5", ZLO | LOI, 5'd0, 1'b1);
    cyc("mul.T6", ZHO | HII, 5'd0, 1'b1);

    IR = 32'h90900000;                       // not R1,R2
    fetch("not");
    cyc("not.T3", GB | RO | ZI, 5'b10010, 1'b1);
    cyc("not.T4", ZLO | GA | RI, 5'd0, 1'b1);

    IR = 32'hD0000000;                       // nop
    fetch("nop");
    IR = 32'h00000000;                       // undefined opcode
    fetch("undef");
    IR = 32'h60000000;                       // opcode 01100, undefined
    fetch("undef12");

    // add with Stop held from T0: only the T5 edge may honour it.
    IR = 32'h18918000; Stop = 1'b1;
    fetch("add");
    cyc("add.T3", GB | RO | YI, 5'd0, 1'b1);
    cyc("add.T4", GC | RO | ZI, 5'b00011, 1'b1);
    cyc("add.T5", ZLO | GA | RI, 5'd0, 1'b1);
    cyc("add.halt0", 19'd0, 5'd0, 1'b0);
    Stop = 1'b0;
    cyc("add.halt1", 19'd0, 5'd0, 1'b0);
    Reset_n = 1'b0; #1;
    chk("halt.async_rst", {strb, ALU_op, Run}, {19'd0, 5'd0, 1'b1});

    IR = 32'hD8000000;                       // halt
    release_rst("h");
    fetch("halt");
    for (int i = 0; i < 20; i++) cyc($sformatf("halt.hold%0d", i), 19'd0, 5'd0, 1'b0);
    Reset_n = 1'b0;

    IR = 32'h20918000;                       // sub, reset during T4
    release_rst("s");
    fetch("sub");
    cyc("sub.T3", GB | RO | YI, 5'd0, 1'b1);
    chk("sub.T4", {strb, ALU_op, Run}, {GC | RO | ZI, 5'b00100, 1'b1});
    #2 Reset_n = 1'b0; #1;
    chk("sub.async_rst", {strb, ALU_op, Run}, {19'd0, 5'd0, 1'b1});
    release_rst("sub2");
    fetch("sub2");
    cyc("sub2.T3", GB | RO | YI, 5'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
